// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring decoder slice.
// State encoding, default geometry, and the ring rotate / one-hot index helpers.
package ring_pkg;

  // Default geometry of the ring and the decoder.
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_REV_W    = 8;

  // Helpers work on a fixed wide container; callers zero-extend and truncate.
  localparam int MAX_W = 32;
  localparam int IDX_W = $clog2(MAX_W);

  // Decoder FSM states.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // One rotation step of a width-bit ring: bit 0 wraps to the top, the rest shift down.
  function automatic logic [MAX_W-1:0] rot_next(input logic [MAX_W-1:0] word, input int width);
    logic [MAX_W-1:0] r;
    logic [IDX_W-1:0] top;
    top = IDX_W'(width - 1);
    r = word >> 1;
    r[top] = word[0];
    return r;
  endfunction

  // Phase of a one-hot word: the top bit is phase 0, bit 0 is phase width-1.
  function automatic int onehot_idx(input logic [MAX_W-1:0] word, input int width);
    logic [MAX_W-1:0] sh;
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      sh = word >> i;
      if (i < width && sh[0]) idx = width - 1 - i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// Ring bus seen by the decoder: generator-side inputs plus decoded status.
// master = ring source / consumer of the status, slave = ring_decoder.
interface ring_decoder_if
  import ring_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REV_W = DEF_REV_W
);
  localparam int PW = $clog2(WIDTH);

  logic             adv;
  logic [WIDTH-1:0] ring_in;
  logic [PW-1:0]    phase;
  logic             phase_valid;
  logic             locked;
  logic             onehot_err;
  logic             seq_err;
  logic [REV_W-1:0] rev_count;

  modport master (
    output adv, ring_in,
    input  phase, phase_valid, locked, onehot_err, seq_err, rev_count
  );

  modport slave (
    input  adv, ring_in,
    output phase, phase_valid, locked, onehot_err, seq_err, rev_count
  );
endinterface

// File: rtl/ring_onehot_chk.sv
// Combinational one-hot check and phase decode of a ring word.
// A word is one-hot when some bit is set and no set bit has another set bit below it.
module ring_onehot_chk
  import ring_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PW    = $clog2(DEF_WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_onehot,
  output logic [PW-1:0]    phase
);

  logic [WIDTH-1:0] dup;

  // dup[gi] marks a set bit that has another set bit somewhere below it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dup
      localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << gi) - 64'd1);
      assign dup[gi] = word[gi] & ((word & LOW_MASK) != '0);
    end
  endgenerate

  assign is_onehot = (|word) & ~(|dup);
  // Only meaningful when is_onehot is set; callers hold their phase otherwise.
  assign phase     = PW'(onehot_idx(MAX_W'(word), WIDTH));

endmodule

// File: rtl/ring_decoder.sv
// Receive-side decoder for a one-hot ring counter.
// Two-stage pipeline: stage 1 samples the ring (ring_q/adv_q, previous word in ring_p),
// stage 2 registers phase, lock state, error flags and the revolution counter.
// Build option RING_DECODER_STICKY_ERR_EN: when defined, FAULT is absorbing and the error
// flags stay high until reset; otherwise flags pulse for one cycle and the block relocks.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int REV_W    = DEF_REV_W
) (
  input logic          clk,
  input logic          reset,
  ring_decoder_if.slave bus
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_CNT + 1);

  logic [WIDTH-1:0] ring_q_reg;
  logic [WIDTH-1:0] ring_p_reg;
  logic             adv_q_reg;
  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;

  logic [PW-1:0]    phase_reg;
  logic             phase_valid_reg;
  logic             locked_reg;
  logic             onehot_err_reg;
  logic             seq_err_reg;
  logic [REV_W-1:0] rev_count_reg;

  logic             q_onehot;
  logic [PW-1:0]    q_phase;
  logic [WIDTH-1:0] exp_word;
  logic             good_step;
  logic             wrap_step;

  ring_onehot_chk #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_chk (
    .word      (ring_q_reg),
    .is_onehot (q_onehot),
    .phase     (q_phase)
  );

  // Step check: the sampled word must equal the previous word rotated (adv) or held (!adv).
  always_comb begin
    exp_word  = adv_q_reg ? WIDTH'(rot_next(MAX_W'(ring_p_reg), WIDTH)) : ring_p_reg;
    good_step = q_onehot && (ring_q_reg == exp_word);
    // A good rotating step landing on phase 0 means the ring just left phase WIDTH-1.
    wrap_step = good_step && adv_q_reg && (q_phase == '0);
  end

  // Sample pipeline, lock FSM, error flags and revolution counter with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ring_q_reg      <= '0;
      ring_p_reg      <= '0;
      adv_q_reg       <= 1'b0;
      state_reg       <= SEARCH;
      cnt_reg         <= '0;
      phase_reg       <= '0;
      phase_valid_reg <= 1'b0;
      locked_reg      <= 1'b0;
      onehot_err_reg  <= 1'b0;
      seq_err_reg     <= 1'b0;
      rev_count_reg   <= '0;
    end else begin
      ring_q_reg <= bus.ring_in;
      adv_q_reg  <= bus.adv;
      ring_p_reg <= ring_q_reg;

      // Phase tracks every valid word in all states and holds across corrupted words.
      phase_valid_reg <= q_onehot;
      if (q_onehot) phase_reg <= q_phase;

      case (state_reg)
        SEARCH: begin
          locked_reg     <= 1'b0;
          onehot_err_reg <= 1'b0;
          seq_err_reg    <= 1'b0;
          if (q_onehot) begin
            state_reg <= LOCKING;
            cnt_reg   <= '0;
          end
        end

        LOCKING: begin
          // A broken run during acquisition is not an error, just a restart.
          onehot_err_reg <= 1'b0;
          seq_err_reg    <= 1'b0;
          if (good_step) begin
            if (cnt_reg == CW'(LOCK_CNT - 1)) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
              cnt_reg    <= CW'(LOCK_CNT);
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            state_reg <= SEARCH;
          end
        end

        LOCKED: begin
          if (!q_onehot) begin
            // A corrupted word outranks a sequence error.
            onehot_err_reg <= 1'b1;
            locked_reg     <= 1'b0;
            state_reg      <= FAULT;
          end else if (!good_step) begin
            seq_err_reg <= 1'b1;
            locked_reg  <= 1'b0;
            state_reg   <= FAULT;
          end else if (wrap_step) begin
            rev_count_reg <= rev_count_reg + 1'b1;
          end
        end

        FAULT: begin
          locked_reg <= 1'b0;
`ifdef RING_DECODER_STICKY_ERR_EN
          // Absorbing until reset; error flags simply keep their value.
          state_reg <= FAULT;
`else
          onehot_err_reg <= 1'b0;
          seq_err_reg    <= 1'b0;
          state_reg      <= SEARCH;
`endif
        end

        default: begin
          state_reg  <= SEARCH;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase       = phase_reg;
  assign bus.phase_valid = phase_valid_reg;
  assign bus.locked      = locked_reg;
  assign bus.onehot_err  = onehot_err_reg;
  assign bus.seq_err     = seq_err_reg;
  assign bus.rev_count   = rev_count_reg;

endmodule
